// File: rtl/fp_pkg.sv
// Shared floating-point types and constants for the add/sub, normalize and writeback path.
package fp_pkg;

  localparam int unsigned FP_EXP_W  = 8;
  localparam int unsigned FP_FRAC_W = 23;

  localparam logic [FP_EXP_W-1:0] EXP_MAX = {FP_EXP_W{1'b1}};

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_FRAC_W-1:0] frac;
  } fp32_t;

  localparam fp32_t INF = '{sign: 1'b0, exp: EXP_MAX, frac: '0};

  typedef enum logic [1:0] {
    S_IDLE,
    S_NORM,
    S_DONE
  } state_e;

endpackage

// File: rtl/fp_normalize.sv
// Post-adder normalization: one-bit-per-cycle left shift, carry fix-up, truncation,
// inf/zero/flush-to-zero handling, valid/ready on both sides.
module fp_normalize
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W  = FP_EXP_W,
  parameter int unsigned FRAC_W = FP_FRAC_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sign,
  input  logic [EXP_W-1:0]          in_exp,
  input  logic [FRAC_W+1:0]         in_mant,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+FRAC_W:0]     f0,
  output logic                      flag_zero,
  output logic                      flag_ovf,
  output logic                      flag_unf
);

  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);

  state_e                  state_q, state_d;
  logic                    sign_q, sign_d;
  logic [EXP_W-1:0]        exp_q, exp_d;
  logic [FRAC_W+1:0]       mant_q, mant_d;
  logic [EXP_W+FRAC_W:0]   f0_q, f0_d;
  logic                    zero_q, zero_d;
  logic                    ovf_q, ovf_d;
  logic                    unf_q, unf_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic [EXP_W-1:0]        exp_inc;

  assign exp_inc = exp_q + EXP_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      f0_q        <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mant_q      <= mant_d;
      f0_q        <= f0_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next state and datapath; f0 and flags only change on entry to DONE or on acceptance.
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    f0_d    = f0_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d = in_sign;
          exp_d  = in_exp;
          mant_d = in_mant;
          zero_d = 1'b0;
          ovf_d  = 1'b0;
          unf_d  = 1'b0;
          if (in_exp == EXP_ONES) begin
            f0_d    = {in_sign, EXP_ONES, {FRAC_W{1'b0}}};
            ovf_d   = 1'b1;
            state_d = S_DONE;
          end else if (in_exp == '0) begin
            f0_d    = {in_sign, {(EXP_W+FRAC_W){1'b0}}};
            zero_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_NORM;
          end
        end
      end

      S_NORM: begin
        if (mant_q == '0) begin
          f0_d    = {sign_q, {(EXP_W+FRAC_W){1'b0}}};
          zero_d  = 1'b1;
          state_d = S_DONE;
        end else if (mant_q[FRAC_W+1]) begin
          // Carry out of the adder: truncating right shift, may overflow to inf.
          if (exp_inc == EXP_ONES) begin
            f0_d  = {sign_q, EXP_ONES, {FRAC_W{1'b0}}};
            ovf_d = 1'b1;
          end else begin
            f0_d  = {sign_q, exp_inc, mant_q[FRAC_W:1]};
          end
          state_d = S_DONE;
        end else if (mant_q[FRAC_W]) begin
          f0_d    = {sign_q, exp_q, mant_q[FRAC_W-1:0]};
          state_d = S_DONE;
        end else if (exp_q == EXP_ONE) begin
          f0_d    = {sign_q, {(EXP_W+FRAC_W){1'b0}}};
          unf_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - EXP_ONE;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign f0        = f0_q;
  assign flag_zero = zero_q;
  assign flag_ovf  = ovf_q;
  assign flag_unf  = unf_q;

endmodule

// File: tb/tb_fp_normalize.sv
// Randomized self-checking bench for fp_normalize against an arithmetic reference model.
module tb_fp_normalize;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] f0;
  logic        flag_zero, flag_ovf, flag_unf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_f0;
  logic [2:0]  exp_fl;   // {zero, ovf, unf}
  logic        prev_valid = 1'b0;
  logic [31:0] prev_f0;
  logic [2:0]  prev_fl;

  always #5 clk = ~clk;

  fp_normalize #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f0        (f0),
    .flag_zero (flag_zero),
    .flag_ovf  (flag_ovf),
    .flag_unf  (flag_unf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Reference: value of the normalized result computed directly from the leading-one position.
  function automatic void model(input bit s, input int e, input int m,
                                output logic [31:0] f, output logic [2:0] fl, output int lat);
    int p, k;
    logic [7:0]  ev;
    logic [22:0] fr;
    fl = 3'b000;
    if (e == 255) begin
      f = {s, 8'hFF, 23'h0}; fl = 3'b010; lat = 1;
    end else if (e == 0) begin
      f = {s, 31'h0}; fl = 3'b100; lat = 1;
    end else if (m == 0) begin
      f = {s, 31'h0}; fl = 3'b100; lat = 2;
    end else if (m >= (1 << 24)) begin
      lat = 2;
      if (e + 1 == 255) begin
        f = {s, 8'hFF, 23'h0}; fl = 3'b010;
      end else begin
        ev = 8'(e + 1);
        fr = 23'((m >> 1) & 32'h7FFFFF);
        f  = {s, ev, fr};
      end
    end else begin
      p = 0;
      for (int i = 0; i < 25; i++) if ((m >> i) & 1) p = i;
      k = 23 - p;
      if (e > k) begin
        ev = 8'(e - k);
        fr = 23'((m << k) & 32'h7FFFFF);
        f  = {s, ev, fr};
        lat = k + 2;
      end else begin
        f = {s, 31'h0}; fl = 3'b001; lat = (e - 1) + 2;
      end
    end
  endfunction

  // Output checker: every cycle the result is presented it must match the model and stay stable.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else if (out_valid) begin
      check("f0", f0, exp_f0);
      check("flags", 32'({flag_zero, flag_ovf, flag_unf}), 32'(exp_fl));
      check("in_ready_in_done", 32'(in_ready), 32'd0);
      if (prev_valid) begin
        check("f0_stable", f0, prev_f0);
        check("flags_stable", 32'({flag_zero, flag_ovf, flag_unf}), 32'(prev_fl));
      end
      prev_valid = 1'b1;
      prev_f0    = f0;
      prev_fl    = {flag_zero, flag_ovf, flag_unf};
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic run_op(input bit s, input logic [7:0] e, input logic [24:0] m, input int hold);
    int lat_req, lat;
    model(s, int'(e), int'(m), exp_f0, exp_fl, lat_req);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_sign   = s;
    in_exp    = e;
    in_mant   = m;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_exp   = $urandom_range(0, 255);
    in_mant  = 25'($urandom);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(lat_req));
    for (int i = 0; i < hold; i++) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    check("in_ready_after", 32'(in_ready), 32'd1);
    check("out_valid_after", 32'(out_valid), 32'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_f0", f0, 32'h0);
    check("rst_flags", 32'({flag_zero, flag_ovf, flag_unf}), 32'd0);
  endtask

  initial begin
    logic [31:0] mf;
    logic [2:0]  mfl;
    int          ml, pos, hold;
    logic [7:0]  re;
    logic [24:0] rm;

    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;

    // Pin the model with hand-computed results.
    model(1'b0, 8'h80, 25'h0800000, mf, mfl, ml);
    check("pin_normal", mf, 32'h40000000); check("pin_normal_lat", 32'(ml), 32'd2);
    model(1'b0, 8'h7F, 25'h1000000, mf, mfl, ml);
    check("pin_carry", mf, 32'h40000000);
    model(1'b0, 8'hFE, 25'h1000000, mf, mfl, ml);
    check("pin_ovf", mf, 32'h7F800000); check("pin_ovf_fl", 32'(mfl), 32'd2);
    model(1'b0, 8'h7F, 25'h0200000, mf, mfl, ml);
    check("pin_shift", mf, 32'h3E800000); check("pin_shift_lat", 32'(ml), 32'd4);
    model(1'b0, 8'h02, 25'h0000001, mf, mfl, ml);
    check("pin_unf", 32'({mfl, 5'd0}) | 32'(ml), 32'h23);

    // Directed cases.
    run_op(1'b0, 8'h80, 25'h0800000, 0);
    run_op(1'b0, 8'h7F, 25'h1000000, 0);
    run_op(1'b0, 8'hFE, 25'h1000000, 0);
    run_op(1'b0, 8'h7F, 25'h0200000, 0);
    run_op(1'b1, 8'h55, 25'h0000000, 0);
    run_op(1'b0, 8'h02, 25'h0000001, 0);
    run_op(1'b1, 8'hFF, 25'h0123456, 0);
    run_op(1'b1, 8'h00, 25'h0800001, 0);
    run_op(1'b0, 8'h18, 25'h0000001, 0);
    run_op(1'b1, 8'h80, 25'h0ABCDEF, 10);

    // Reset two cycles into a long shift sequence.
    @(negedge clk);
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'h7F; in_mant = 25'h0000001;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    run_op(1'b0, 8'h80, 25'h0800000, 0);

    // Randomized operations with leading-one position spread across the mantissa.
    for (int n = 0; n < 300; n++) begin
      pos  = $urandom_range(0, 25);
      rm   = (pos == 25) ? 25'h0 : ((25'($urandom) & ((25'h1 << pos) - 25'h1)) | (25'h1 << pos));
      case ($urandom_range(0, 7))
        0:       re = 8'h00;
        1:       re = 8'hFF;
        2:       re = 8'hFE;
        3:       re = 8'($urandom_range(1, 24));
        default: re = 8'($urandom_range(1, 254));
      endcase
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
      run_op(1'($urandom), re, rm, hold);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
